memory_responder: RTL and testbench
===================================

Name: memory_responder

Overview:
- Memory-side responder for the CPU's MAR/MDR datapath.
- Accepts read/write requests (address from MAR, write data from MDR) and holds a synchronous word-addressed RAM.
- After a fixed, parameterised wait, it returns read data on Mdatain (the MDR's memory-input path) and pulses ready.
- It is the other end of the MDR's read/Mdatain interface: the MDR consumes, this block produces.

Parameters:
- DATA_WIDTH, 32, word width of RAM, MDRout and Mdatain.
- DEPTH, 512, number of RAM words.
- ADDR_WIDTH, 9, index bits used from the address (log2 of DEPTH).
- LATENCY, 2, ACCESS-state cycles per access; legal range 1 to 15.

Ports:
- clock, in, 1, rising-edge clock.
- clear, in, 1, synchronous active-high reset.
- read, in, 1, level read request from the control unit.
- write, in, 1, level write request from the control unit.
- address, in, 32, word address (MAR output).
- MDRout, in, DATA_WIDTH, write data (MDR output).
- Mdatain, out, DATA_WIDTH, read data to the MDR input mux; registered.
- ready, out, 1, one-cycle completion pulse; registered.
- busy, out, 1, high whenever state is not IDLE.
- err, out, 1, sticky out-of-range flag; present only with MEM_RANGE_CHECK_EN.

Behaviour:
- Reset: clear is sampled on a rising clock edge and overrides everything.
  - state=IDLE, Mdatain=0, ready=0, busy=0, err=0, counter=0.
  - RAM contents are not cleared.
  - Reset during ACCESS aborts the operation; a pending write is not performed.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - On an edge with read or write high, latch address[ADDR_WIDTH-1:0] (or the full address with the macro), MDRout and the op.
  - Load counter=LATENCY-1 and go to ACCESS.
  - If read and write are both high, the op is a read and write is ignored.
  - Requests are sampled only in IDLE.
- ACCESS:
  - If counter==0, perform the op on this edge and go to DONE.
    - Read: Mdatain <= RAM[latched index].
    - Write: RAM[latched index] <= latched data; Mdatain unchanged.
  - Otherwise decrement counter.
  - Changes on address, MDRout, read and write are ignored during ACCESS; the latched copies are used.
- DONE: ready=1 for exactly this cycle, then unconditionally return to IDLE.
- Timing: acceptance at edge E means the RAM update / Mdatain update occurs at edge E+LATENCY, and ready is high for the cycle after E+LATENCY.
  - Throughput is one access per LATENCY+2 cycles.
- busy=1 in ACCESS and DONE.
- Requester rule: deassert read/write in the cycle ready is seen. A request still high in IDLE starts a new access, which is legal and is processed normally.
- Mdatain holds its last read value until the next read completes or clear.
- Address width: without the macro, only the low ADDR_WIDTH bits are used, so addresses wrap modulo DEPTH. Example: 0x200 aliases 0x000 when DEPTH=512.

Optional Feature:
- Macro: MEM_RANGE_CHECK_EN.
- Defined:
  - The err port exists.
  - The full 32-bit address is latched.
  - If the latched address >= DEPTH, the access still takes LATENCY cycles and pulses ready.
    - A read returns Mdatain=0.
    - A write is dropped.
    - err is set at the completion edge.
  - err stays 1 until clear.
- Undefined:
  - No err port.
  - Addresses wrap modulo DEPTH as described above.

Test Plan:
- Reset: assert clear for 2 cycles during an ACCESS write of 0xDEADBEEF to 0x010 -> Mdatain=0, ready=0, busy=0; a subsequent read of 0x010 does not return 0xDEADBEEF.
- Write then read, LATENCY=2: write 0x12345678 to 0x005 at edge E -> ready high in the cycle after E+2. Then read 0x005 -> Mdatain=0x12345678 from edge E'+2, ready pulses one cycle, Mdatain holds afterwards.
- Held request: keep read high through ready on address 0x003 -> a second access starts on the IDLE cycle; two ready pulses spaced LATENCY+2 cycles apart.
- Simultaneous read+write at 0x007 holding 0xAAAA5555 with MDRout=0x0 -> Mdatain=0xAAAA5555; RAM[0x007] unchanged on re-read.
- Request changes mid-access: change address from 0x001 to 0x002 during ACCESS -> data returned is from 0x001.
- Range: read 0x200.
  - Without macro -> returns RAM[0x000].
  - With MEM_RANGE_CHECK_EN -> Mdatain=0, ready pulses, err=1 and sticky until clear.

Source files
------------

// File: rtl/memory_responder.sv
// Memory-side responder for the MAR/MDR datapath: a fixed-latency word-addressed RAM.
// Optional macro MEM_RANGE_CHECK_EN adds full-address range checking and a sticky err output.
module memory_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = 9,
    parameter int LATENCY    = 2
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           address,
    input  logic [DATA_WIDTH-1:0] MDRout,
    output logic [DATA_WIDTH-1:0] Mdatain,
    output logic                  ready,
    output logic                  busy
`ifdef MEM_RANGE_CHECK_EN
    ,
    output logic                  err
`endif
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

`ifdef MEM_RANGE_CHECK_EN
    localparam int LAW = 32;
`else
    localparam int LAW = ADDR_WIDTH;
`endif

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  op_wr_q, op_wr_d;
    logic [LAW-1:0]        addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  ready_q, ready_d;
    logic [DATA_WIDTH-1:0] mdatain_q;
    logic                  do_op;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] idx;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign idx = addr_q[ADDR_WIDTH-1:0];

`ifdef MEM_RANGE_CHECK_EN
    logic err_q, err_d;
    assign in_range = (addr_q < 32'(DEPTH));
    assign err      = err_q;
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^address[31:ADDR_WIDTH];
    assign in_range       = 1'b1;
`endif

    assign do_op = (state_q == ACCESS) && (cnt_q == 4'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        ready_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (read || write) begin
                    // read wins when both are requested
                    op_wr_d = write && !read;
                    addr_d  = address[LAW-1:0];
                    data_d  = MDRout;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef MEM_RANGE_CHECK_EN
    always_comb begin
        err_d = err_q;
        if (do_op && !in_range) err_d = 1'b1;
    end
`endif

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
`ifdef MEM_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ready_q <= ready_d;
`ifdef MEM_RANGE_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // RAM contents survive clear; an access aborted by clear never writes
    always_ff @(posedge clock) begin
        if (!clear && do_op && op_wr_q && in_range) mem[idx] <= data_q;
    end

    always_ff @(posedge clock) begin
        if (clear)
            mdatain_q <= '0;
        else if (do_op && !op_wr_q)
            mdatain_q <= in_range ? mem[idx] : '0;
    end

    assign Mdatain = mdatain_q;
    assign ready   = ready_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: randomized accesses against an array model of the RAM.
module tb_memory_responder;
    localparam int DW    = 32;
    localparam int DEPTH = 512;
    localparam int AW    = 9;
    localparam int LAT   = 2;

    logic          clock = 1'b0;
    logic          clear = 1'b1;
    logic          read = 1'b0, write = 1'b0;
    logic [31:0]   address = '0;
    logic [DW-1:0] MDRout = '0;
    logic [DW-1:0] Mdatain;
    logic          ready, busy;
`ifdef MEM_RANGE_CHECK_EN
    logic          err;
`endif

    memory_responder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clock(clock), .clear(clear), .read(read), .write(write),
        .address(address), .MDRout(MDRout), .Mdatain(Mdatain),
        .ready(ready), .busy(busy)
`ifdef MEM_RANGE_CHECK_EN
        , .err(err)
`endif
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;
    exp_t q[$];
    exp_t e;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: the RAM as an array, plus last value read and sticky range error
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] last_m = '0;
    bit            err_m = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] ref_access(input bit rd, input bit wr,
                                                 input logic [31:0] a, input logic [DW-1:0] d);
        bit ok;
        int i;
`ifdef MEM_RANGE_CHECK_EN
        ok = (a < DEPTH);
        i  = ok ? int'(a) : 0;
`else
        ok = 1;
        i  = int'(a % DEPTH);
`endif
        if (!ok) err_m = 1;
        if (rd) last_m = ok ? model[i] : '0;
        else if (wr && ok) model[i] = d;
        return last_m;
    endfunction

    // monitor: every ready pulse must match the oldest expected completion
    always @(negedge clock) begin
        if (!clear && ready === 1'b1) begin
            check("busy_at_ready", {31'd0, busy}, 32'd1);
            if (q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_ready: ready at cycle %0d, none expected", cyc);
            end else begin
                e = q.pop_front();
                check("mdatain", Mdatain, e.data);
                check("ready_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_ready();
        bit got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clock);
            if (ready === 1'b1) got = 1;
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL ready_timeout: ready got 0 expected 1 within 50 cycles");
        end
    endtask

    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [DW-1:0] d);
        exp_t x;
        @(negedge clock);
        read = rd; write = wr; address = a; MDRout = d;
        @(posedge clock); #1;
        x.data = ref_access(rd, wr, a, d);
        x.cyc  = cyc + LAT;
        q.push_back(x);
        // scramble the request mid-access; the latched copies must be used
        @(negedge clock);
        read = 0; write = 0; address = a + 1; MDRout = ~d;
        wait_ready();
    endtask

    task automatic reset_pulse(input int n);
        @(negedge clock);
        clear = 1; read = 0; write = 0;
        repeat (n) @(posedge clock);
        @(negedge clock);
        check("rst_mdatain", Mdatain, '0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
`ifdef MEM_RANGE_CHECK_EN
        check("rst_err", {31'd0, err}, 32'd0);
        err_m = 0;
`endif
        clear = 0;
        last_m = '0;
    endtask

    initial begin
        logic [DW-1:0] d;
        exp_t x;
        int c0;
        reset_pulse(3);

        // preload every word with known data
        for (int i = 0; i < DEPTH; i++) begin
            d = $urandom;
            if (d == 32'hDEADBEEF) d = d ^ 32'h1;
            access(0, 1, i, d);
        end

        // clear during an in-flight write aborts it
        @(negedge clock);
        write = 1; address = 32'h010; MDRout = 32'hDEADBEEF;
        @(posedge clock);
        reset_pulse(2);
        access(1, 0, 32'h010, 0);
        check("abort_ram", model[16], Mdatain);

        // write then read
        access(0, 1, 32'h005, 32'h12345678);
        access(1, 0, 32'h005, 0);
        check("read_back", Mdatain, 32'h12345678);
        repeat (3) @(negedge clock);
        check("mdatain_hold", Mdatain, 32'h12345678);

        // held read: two back-to-back accesses LAT+2 apart
        @(negedge clock);
        read = 1; write = 0; address = 32'h003;
        @(posedge clock); #1;
        c0 = cyc;
        x.data = ref_access(1, 0, 32'h003, 0); x.cyc = c0 + LAT;         q.push_back(x);
        x.data = ref_access(1, 0, 32'h003, 0); x.cyc = c0 + 2 * LAT + 2; q.push_back(x);
        wait_ready();
        wait_ready();
        read = 0;

        // read+write together is a read
        access(0, 1, 32'h007, 32'hAAAA5555);
        access(1, 1, 32'h007, 32'h0);
        check("rw_read", Mdatain, 32'hAAAA5555);
        access(1, 0, 32'h007, 0);
        check("rw_ram_unchanged", Mdatain, 32'hAAAA5555);

        // address changes during ACCESS are ignored
        access(0, 1, 32'h001, 32'h11111111);
        access(0, 1, 32'h002, 32'h22222222);
        access(1, 0, 32'h001, 0);
        check("latched_addr", Mdatain, 32'h11111111);

        // 0x200: aliases 0x000, or out of range with the range check
        access(1, 0, 32'h200, 0);
`ifdef MEM_RANGE_CHECK_EN
        check("range_mdatain", Mdatain, '0);
        check("range_err", {31'd0, err}, 32'd1);
        access(1, 0, 32'h004, 0);
        check("err_sticky", {31'd0, err}, 32'd1);
        reset_pulse(1);
`else
        check("wrap_mdatain", Mdatain, model[0]);
`endif

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            int op;
            op = $urandom_range(0, 2);
            a  = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, DEPTH - 1);
            access(op != 1, op != 0, a, $urandom);
        end
`ifdef MEM_RANGE_CHECK_EN
        check("err_final", {31'd0, err}, {31'd0, err_m});
`endif
        repeat (4) @(negedge clock);
        check("queue_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
